// File: rtl/exe_operands_pipe_pkg.sv
// Shared execute-stage encodings: unit indices, scoreboard sizing, rd_type codes.
package exe_operands_pipe_pkg;
    localparam int H_ALU0 = 0;
    localparam int H_ALU1 = 1;
    localparam int H_BEU = 2;
    localparam int H_LSU = 3;
    localparam int H_EXE_UNIT_WIDTH = 4;
    localparam int SCOREBOARD_SIZE_WIDTH = 3;

    localparam logic [1:0] RD_TYPE_NONE = 2'b00;
    localparam logic [1:0] RD_TYPE_INT = 2'b01;
    localparam logic [1:0] RD_TYPE_FP = 2'b10;

    // x0 is hardwired, so a writeback to it never supplies a forwarded value.
    function automatic logic wb_hit(input logic wb_valid, input logic [1:0] wb_rd_type,
                                    input logic [4:0] wb_rd, input logic rs_valid,
                                    input logic [4:0] rs_idx, input logic [1:0] rd_int);
        return wb_valid && (wb_rd_type == rd_int) && (wb_rd != 5'd0) && rs_valid && (rs_idx == wb_rd);
    endfunction
endpackage

// File: rtl/exe_operands_pipe_fwd_mux.sv
// Selects the freshest value for one source operand; wb1 is younger and wins.
module exe_fwd_mux
    import exe_operands_pipe_pkg::*;
#(
    parameter int XLEN = 64,
    parameter logic [1:0] RD_INT = RD_TYPE_INT
) (
    input  logic            rs_valid,
    input  logic [4:0]      rs_idx,
    input  logic [XLEN-1:0] rs_value,
    input  logic            wb0_valid,
    input  logic [1:0]      wb0_rd_type,
    input  logic [4:0]      wb0_rd,
    input  logic [XLEN-1:0] wb0_value,
    input  logic            wb1_valid,
    input  logic [1:0]      wb1_rd_type,
    input  logic [4:0]      wb1_rd,
    input  logic [XLEN-1:0] wb1_value,
    output logic [XLEN-1:0] fwd_value
);
    logic hit0, hit1;

    assign hit0 = wb_hit(wb0_valid, wb0_rd_type, wb0_rd, rs_valid, rs_idx, RD_INT);
    assign hit1 = wb_hit(wb1_valid, wb1_rd_type, wb1_rd, rs_valid, rs_idx, RD_INT);
    assign fwd_value = hit1 ? wb1_value : (hit0 ? wb0_value : rs_value);
endmodule

// File: rtl/exe_operands_pipe.sv
// Two-lane operand register between issue and the execute sequencer, with writeback
// forwarding into both captured and held operands; 1-cycle latency, holds while exe not ready.
module exe_operands_pipe
    import exe_operands_pipe_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int SID_W = SCOREBOARD_SIZE_WIDTH + 1,
    parameter int HU_W = H_EXE_UNIT_WIDTH,
    parameter logic [1:0] RD_INT = RD_TYPE_INT,
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic issue_valid_i,
    output logic issue_ready_o,
    input  logic inst0_issue_valid_i, inst1_issue_valid_i,
    input  logic [63:0] inst0_issue_pc_i, inst1_issue_pc_i,
    input  logic [31:0] inst0_issue_inst_i, inst1_issue_inst_i,
    input  logic inst0_issue_rs1_valid_i, inst0_issue_rs2_valid_i, inst0_issue_rs3_valid_i,
    input  logic inst1_issue_rs1_valid_i, inst1_issue_rs2_valid_i, inst1_issue_rs3_valid_i,
    input  logic [4:0] inst0_issue_rs1_idx_i, inst0_issue_rs2_idx_i, inst0_issue_rs3_idx_i,
    input  logic [4:0] inst1_issue_rs1_idx_i, inst1_issue_rs2_idx_i, inst1_issue_rs3_idx_i,
    input  logic [XLEN-1:0] inst0_issue_rs1_value_i, inst0_issue_rs2_value_i, inst0_issue_rs3_value_i,
    input  logic [XLEN-1:0] inst1_issue_rs1_value_i, inst1_issue_rs2_value_i, inst1_issue_rs3_value_i,
    input  logic [1:0] inst0_issue_rd_type_i, inst1_issue_rd_type_i,
    input  logic [4:0] inst0_issue_rd_i, inst1_issue_rd_i,
    input  logic [HU_W-1:0] inst0_issue_h_exe_unit_i, inst1_issue_h_exe_unit_i,
    input  logic [3:0] inst0_issue_func_code_i, inst1_issue_func_code_i,
    input  logic [2:0] inst0_issue_func3_i, inst1_issue_func3_i,
    input  logic [1:0] inst0_issue_func2_i, inst1_issue_func2_i,
    input  logic inst0_issue_endsim_i, inst1_issue_endsim_i,
    input  logic inst0_issue_auipc_i, inst1_issue_auipc_i,
    input  logic [SID_W-1:0] inst0_issue_sid_i, inst1_issue_sid_i,
    input  logic wb0_valid_i, wb1_valid_i,
    input  logic [1:0] wb0_rd_type_i, wb1_rd_type_i,
    input  logic [4:0] wb0_rd_i, wb1_rd_i,
    input  logic [XLEN-1:0] wb0_value_i, wb1_value_i,
    input  logic exe_ready_i,
    output logic inst0_operands_valid_o, inst1_operands_valid_o,
    output logic [63:0] inst0_operands_pc_o, inst1_operands_pc_o,
    output logic [31:0] inst0_operands_inst_o, inst1_operands_inst_o,
    output logic inst0_operands_rs1_valid_o, inst0_operands_rs2_valid_o, inst0_operands_rs3_valid_o,
    output logic inst1_operands_rs1_valid_o, inst1_operands_rs2_valid_o, inst1_operands_rs3_valid_o,
    output logic [4:0] inst0_operands_rs1_idx_o, inst0_operands_rs2_idx_o, inst0_operands_rs3_idx_o,
    output logic [4:0] inst1_operands_rs1_idx_o, inst1_operands_rs2_idx_o, inst1_operands_rs3_idx_o,
    output logic [XLEN-1:0] inst0_operands_rs1_value_o, inst0_operands_rs2_value_o, inst0_operands_rs3_value_o,
    output logic [XLEN-1:0] inst1_operands_rs1_value_o, inst1_operands_rs2_value_o, inst1_operands_rs3_value_o,
    output logic [1:0] inst0_operands_rd_type_o, inst1_operands_rd_type_o,
    output logic [4:0] inst0_operands_rd_o, inst1_operands_rd_o,
    output logic [HU_W-1:0] inst0_operands_h_exe_unit_o, inst1_operands_h_exe_unit_o,
    output logic [3:0] inst0_operands_func_code_o, inst1_operands_func_code_o,
    output logic [2:0] inst0_operands_func3_o, inst1_operands_func3_o,
    output logic [1:0] inst0_operands_func2_o, inst1_operands_func2_o,
    output logic inst0_operands_endsim_o, inst1_operands_endsim_o,
    output logic inst0_operands_auipc_o, inst1_operands_auipc_o,
    output logic [SID_W-1:0] inst0_operands_sid_o, inst1_operands_sid_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    typedef struct packed {
        logic            valid;
        logic [63:0]     pc;
        logic [31:0]     inst;
        logic [2:0]      rs_valid;
        logic [2:0][4:0] rs_idx;
        logic [1:0]      rd_type;
        logic [4:0]      rd;
        logic [HU_W-1:0] hu;
        logic [3:0]      func_code;
        logic [2:0]      func3;
        logic [1:0]      func2;
        logic            endsim;
        logic            auipc;
        logic [SID_W-1:0] sid;
    } lane_t;

    lane_t issue_l [2];
    lane_t lane_q [2];
    logic [XLEN-1:0] val_in [2][3];
    logic [XLEN-1:0] val_q [2][3];
    logic [XLEN-1:0] val_fwd [2][3];
    logic occ, load, hold;

    assign issue_l[0] = {inst0_issue_valid_i, inst0_issue_pc_i, inst0_issue_inst_i,
        {inst0_issue_rs3_valid_i, inst0_issue_rs2_valid_i, inst0_issue_rs1_valid_i},
        {inst0_issue_rs3_idx_i, inst0_issue_rs2_idx_i, inst0_issue_rs1_idx_i},
        inst0_issue_rd_type_i, inst0_issue_rd_i, inst0_issue_h_exe_unit_i, inst0_issue_func_code_i,
        inst0_issue_func3_i, inst0_issue_func2_i, inst0_issue_endsim_i, inst0_issue_auipc_i, inst0_issue_sid_i};
    assign issue_l[1] = {inst1_issue_valid_i, inst1_issue_pc_i, inst1_issue_inst_i,
        {inst1_issue_rs3_valid_i, inst1_issue_rs2_valid_i, inst1_issue_rs1_valid_i},
        {inst1_issue_rs3_idx_i, inst1_issue_rs2_idx_i, inst1_issue_rs1_idx_i},
        inst1_issue_rd_type_i, inst1_issue_rd_i, inst1_issue_h_exe_unit_i, inst1_issue_func_code_i,
        inst1_issue_func3_i, inst1_issue_func2_i, inst1_issue_endsim_i, inst1_issue_auipc_i, inst1_issue_sid_i};
    assign val_in[0] = '{inst0_issue_rs1_value_i, inst0_issue_rs2_value_i, inst0_issue_rs3_value_i};
    assign val_in[1] = '{inst1_issue_rs1_value_i, inst1_issue_rs2_value_i, inst1_issue_rs3_value_i};

    assign occ = lane_q[0].valid | lane_q[1].valid;
    assign issue_ready_o = !flush_i && (!occ || exe_ready_i);
    assign load = issue_valid_i && issue_ready_o;
    assign hold = occ && !exe_ready_i;

    // One mux per operand, fed from the incoming pair on load and the held pair otherwise.
    for (genvar l = 0; l < 2; l++) begin : g_lane
        for (genvar j = 0; j < 3; j++) begin : g_rs
            logic            src_valid;
            logic [4:0]      src_idx;
            logic [XLEN-1:0] src_value;

            assign src_valid = load ? (issue_l[l].valid & issue_l[l].rs_valid[j])
                                    : (lane_q[l].valid & lane_q[l].rs_valid[j]);
            assign src_idx = load ? issue_l[l].rs_idx[j] : lane_q[l].rs_idx[j];
            assign src_value = load ? val_in[l][j] : val_q[l][j];

            exe_fwd_mux #(.XLEN(XLEN), .RD_INT(RD_INT)) u_fwd (
                .rs_valid(src_valid), .rs_idx(src_idx), .rs_value(src_value),
                .wb0_valid(wb0_valid_i), .wb0_rd_type(wb0_rd_type_i), .wb0_rd(wb0_rd_i), .wb0_value(wb0_value_i),
                .wb1_valid(wb1_valid_i), .wb1_rd_type(wb1_rd_type_i), .wb1_rd(wb1_rd_i), .wb1_value(wb1_value_i),
                .fwd_value(val_fwd[l][j])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                lane_q[l] <= '0;
                for (int j = 0; j < 3; j++) val_q[l][j] <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (flush_i) begin
                    lane_q[l].valid <= 1'b0;
                end else if (load) begin
                    lane_q[l] <= issue_l[l];
                    for (int j = 0; j < 3; j++) val_q[l][j] <= val_fwd[l][j];
                end else if (hold) begin
                    for (int j = 0; j < 3; j++) val_q[l][j] <= val_fwd[l][j];
                end else if (occ) begin
                    lane_q[l].valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_o <= '0;
        else if (hold && !flush_i && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
    end

    assign {inst0_operands_valid_o, inst0_operands_pc_o, inst0_operands_inst_o,
            inst0_operands_rs3_valid_o, inst0_operands_rs2_valid_o, inst0_operands_rs1_valid_o,
            inst0_operands_rs3_idx_o, inst0_operands_rs2_idx_o, inst0_operands_rs1_idx_o,
            inst0_operands_rd_type_o, inst0_operands_rd_o, inst0_operands_h_exe_unit_o, inst0_operands_func_code_o,
            inst0_operands_func3_o, inst0_operands_func2_o, inst0_operands_endsim_o, inst0_operands_auipc_o,
            inst0_operands_sid_o} = lane_q[0];
    assign {inst1_operands_valid_o, inst1_operands_pc_o, inst1_operands_inst_o,
            inst1_operands_rs3_valid_o, inst1_operands_rs2_valid_o, inst1_operands_rs1_valid_o,
            inst1_operands_rs3_idx_o, inst1_operands_rs2_idx_o, inst1_operands_rs1_idx_o,
            inst1_operands_rd_type_o, inst1_operands_rd_o, inst1_operands_h_exe_unit_o, inst1_operands_func_code_o,
            inst1_operands_func3_o, inst1_operands_func2_o, inst1_operands_endsim_o, inst1_operands_auipc_o,
            inst1_operands_sid_o} = lane_q[1];
    assign inst0_operands_rs1_value_o = val_q[0][0];
    assign inst0_operands_rs2_value_o = val_q[0][1];
    assign inst0_operands_rs3_value_o = val_q[0][2];
    assign inst1_operands_rs1_value_o = val_q[1][0];
    assign inst1_operands_rs2_value_o = val_q[1][1];
    assign inst1_operands_rs3_value_o = val_q[1][2];
endmodule

// File: tb/tb_exe_operands_pipe.sv
// Directed bench for exe_operands_pipe: load, hold/stall count, forwarding, flush, partial pair, async reset.
module tb_exe_operands_pipe;
    logic clk = 1'b0, rst_n, flush_i, issue_valid_i, issue_ready_o, exe_ready_i;
    logic inst0_issue_valid_i, inst1_issue_valid_i;
    logic [63:0] inst0_issue_pc_i, inst1_issue_pc_i;
    logic [31:0] inst0_issue_inst_i, inst1_issue_inst_i;
    logic inst0_issue_rs1_valid_i, inst0_issue_rs2_valid_i, inst0_issue_rs3_valid_i;
    logic inst1_issue_rs1_valid_i, inst1_issue_rs2_valid_i, inst1_issue_rs3_valid_i;
    logic [4:0] inst0_issue_rs1_idx_i, inst0_issue_rs2_idx_i, inst0_issue_rs3_idx_i;
    logic [4:0] inst1_issue_rs1_idx_i, inst1_issue_rs2_idx_i, inst1_issue_rs3_idx_i;
    logic [63:0] inst0_issue_rs1_value_i, inst0_issue_rs2_value_i, inst0_issue_rs3_value_i;
    logic [63:0] inst1_issue_rs1_value_i, inst1_issue_rs2_value_i, inst1_issue_rs3_value_i;
    logic [1:0] inst0_issue_rd_type_i, inst1_issue_rd_type_i;
    logic [4:0] inst0_issue_rd_i, inst1_issue_rd_i;
    logic [3:0] inst0_issue_h_exe_unit_i, inst1_issue_h_exe_unit_i;
    logic [3:0] inst0_issue_func_code_i, inst1_issue_func_code_i;
    logic [2:0] inst0_issue_func3_i, inst1_issue_func3_i;
    logic [1:0] inst0_issue_func2_i, inst1_issue_func2_i;
    logic inst0_issue_endsim_i, inst1_issue_endsim_i, inst0_issue_auipc_i, inst1_issue_auipc_i;
    logic [3:0] inst0_issue_sid_i, inst1_issue_sid_i;
    logic wb0_valid_i, wb1_valid_i;
    logic [1:0] wb0_rd_type_i, wb1_rd_type_i;
    logic [4:0] wb0_rd_i, wb1_rd_i;
    logic [63:0] wb0_value_i, wb1_value_i;
    logic inst0_operands_valid_o, inst1_operands_valid_o;
    logic [63:0] inst0_operands_pc_o, inst1_operands_pc_o;
    logic [31:0] inst0_operands_inst_o, inst1_operands_inst_o;
    logic inst0_operands_rs1_valid_o, inst0_operands_rs2_valid_o, inst0_operands_rs3_valid_o;
    logic inst1_operands_rs1_valid_o, inst1_operands_rs2_valid_o, inst1_operands_rs3_valid_o;
    logic [4:0] inst0_operands_rs1_idx_o, inst0_operands_rs2_idx_o, inst0_operands_rs3_idx_o;
    logic [4:0] inst1_operands_rs1_idx_o, inst1_operands_rs2_idx_o, inst1_operands_rs3_idx_o;
    logic [63:0] inst0_operands_rs1_value_o, inst0_operands_rs2_value_o, inst0_operands_rs3_value_o;
    logic [63:0] inst1_operands_rs1_value_o, inst1_operands_rs2_value_o, inst1_operands_rs3_value_o;
    logic [1:0] inst0_operands_rd_type_o, inst1_operands_rd_type_o;
    logic [4:0] inst0_operands_rd_o, inst1_operands_rd_o;
    logic [3:0] inst0_operands_h_exe_unit_o, inst1_operands_h_exe_unit_o;
    logic [3:0] inst0_operands_func_code_o, inst1_operands_func_code_o;
    logic [2:0] inst0_operands_func3_o, inst1_operands_func3_o;
    logic [1:0] inst0_operands_func2_o, inst1_operands_func2_o;
    logic inst0_operands_endsim_o, inst1_operands_endsim_o, inst0_operands_auipc_o, inst1_operands_auipc_o;
    logic [3:0] inst0_operands_sid_o, inst1_operands_sid_o;
    logic [31:0] stall_cnt_o;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    exe_operands_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .inst0_issue_valid_i(inst0_issue_valid_i), .inst1_issue_valid_i(inst1_issue_valid_i),
        .inst0_issue_pc_i(inst0_issue_pc_i), .inst1_issue_pc_i(inst1_issue_pc_i),
        .inst0_issue_inst_i(inst0_issue_inst_i), .inst1_issue_inst_i(inst1_issue_inst_i),
        .inst0_issue_rs1_valid_i(inst0_issue_rs1_valid_i), .inst0_issue_rs2_valid_i(inst0_issue_rs2_valid_i),
        .inst0_issue_rs3_valid_i(inst0_issue_rs3_valid_i), .inst1_issue_rs1_valid_i(inst1_issue_rs1_valid_i),
        .inst1_issue_rs2_valid_i(inst1_issue_rs2_valid_i), .inst1_issue_rs3_valid_i(inst1_issue_rs3_valid_i),
        .inst0_issue_rs1_idx_i(inst0_issue_rs1_idx_i), .inst0_issue_rs2_idx_i(inst0_issue_rs2_idx_i),
        .inst0_issue_rs3_idx_i(inst0_issue_rs3_idx_i), .inst1_issue_rs1_idx_i(inst1_issue_rs1_idx_i),
        .inst1_issue_rs2_idx_i(inst1_issue_rs2_idx_i), .inst1_issue_rs3_idx_i(inst1_issue_rs3_idx_i),
        .inst0_issue_rs1_value_i(inst0_issue_rs1_value_i), .inst0_issue_rs2_value_i(inst0_issue_rs2_value_i),
        .inst0_issue_rs3_value_i(inst0_issue_rs3_value_i), .inst1_issue_rs1_value_i(inst1_issue_rs1_value_i),
        .inst1_issue_rs2_value_i(inst1_issue_rs2_value_i), .inst1_issue_rs3_value_i(inst1_issue_rs3_value_i),
        .inst0_issue_rd_type_i(inst0_issue_rd_type_i), .inst1_issue_rd_type_i(inst1_issue_rd_type_i),
        .inst0_issue_rd_i(inst0_issue_rd_i), .inst1_issue_rd_i(inst1_issue_rd_i),
        .inst0_issue_h_exe_unit_i(inst0_issue_h_exe_unit_i), .inst1_issue_h_exe_unit_i(inst1_issue_h_exe_unit_i),
        .inst0_issue_func_code_i(inst0_issue_func_code_i), .inst1_issue_func_code_i(inst1_issue_func_code_i),
        .inst0_issue_func3_i(inst0_issue_func3_i), .inst1_issue_func3_i(inst1_issue_func3_i),
        .inst0_issue_func2_i(inst0_issue_func2_i), .inst1_issue_func2_i(inst1_issue_func2_i),
        .inst0_issue_endsim_i(inst0_issue_endsim_i), .inst1_issue_endsim_i(inst1_issue_endsim_i),
        .inst0_issue_auipc_i(inst0_issue_auipc_i), .inst1_issue_auipc_i(inst1_issue_auipc_i),
        .inst0_issue_sid_i(inst0_issue_sid_i), .inst1_issue_sid_i(inst1_issue_sid_i),
        .wb0_valid_i(wb0_valid_i), .wb1_valid_i(wb1_valid_i), .wb0_rd_type_i(wb0_rd_type_i),
        .wb1_rd_type_i(wb1_rd_type_i), .wb0_rd_i(wb0_rd_i), .wb1_rd_i(wb1_rd_i),
        .wb0_value_i(wb0_value_i), .wb1_value_i(wb1_value_i), .exe_ready_i(exe_ready_i),
        .inst0_operands_valid_o(inst0_operands_valid_o), .inst1_operands_valid_o(inst1_operands_valid_o),
        .inst0_operands_pc_o(inst0_operands_pc_o), .inst1_operands_pc_o(inst1_operands_pc_o),
        .inst0_operands_inst_o(inst0_operands_inst_o), .inst1_operands_inst_o(inst1_operands_inst_o),
        .inst0_operands_rs1_valid_o(inst0_operands_rs1_valid_o), .inst0_operands_rs2_valid_o(inst0_operands_rs2_valid_o),
        .inst0_operands_rs3_valid_o(inst0_operands_rs3_valid_o), .inst1_operands_rs1_valid_o(inst1_operands_rs1_valid_o),
        .inst1_operands_rs2_valid_o(inst1_operands_rs2_valid_o), .inst1_operands_rs3_valid_o(inst1_operands_rs3_valid_o),
        .inst0_operands_rs1_idx_o(inst0_operands_rs1_idx_o), .inst0_operands_rs2_idx_o(inst0_operands_rs2_idx_o),
        .inst0_operands_rs3_idx_o(inst0_operands_rs3_idx_o), .inst1_operands_rs1_idx_o(inst1_operands_rs1_idx_o),
        .inst1_operands_rs2_idx_o(inst1_operands_rs2_idx_o), .inst1_operands_rs3_idx_o(inst1_operands_rs3_idx_o),
        .inst0_operands_rs1_value_o(inst0_operands_rs1_value_o), .inst0_operands_rs2_value_o(inst0_operands_rs2_value_o),
        .inst0_operands_rs3_value_o(inst0_operands_rs3_value_o), .inst1_operands_rs1_value_o(inst1_operands_rs1_value_o),
        .inst1_operands_rs2_value_o(inst1_operands_rs2_value_o), .inst1_operands_rs3_value_o(inst1_operands_rs3_value_o),
        .inst0_operands_rd_type_o(inst0_operands_rd_type_o), .inst1_operands_rd_type_o(inst1_operands_rd_type_o),
        .inst0_operands_rd_o(inst0_operands_rd_o), .inst1_operands_rd_o(inst1_operands_rd_o),
        .inst0_operands_h_exe_unit_o(inst0_operands_h_exe_unit_o), .inst1_operands_h_exe_unit_o(inst1_operands_h_exe_unit_o),
        .inst0_operands_func_code_o(inst0_operands_func_code_o), .inst1_operands_func_code_o(inst1_operands_func_code_o),
        .inst0_operands_func3_o(inst0_operands_func3_o), .inst1_operands_func3_o(inst1_operands_func3_o),
        .inst0_operands_func2_o(inst0_operands_func2_o), .inst1_operands_func2_o(inst1_operands_func2_o),
        .inst0_operands_endsim_o(inst0_operands_endsim_o), .inst1_operands_endsim_o(inst1_operands_endsim_o),
        .inst0_operands_auipc_o(inst0_operands_auipc_o), .inst1_operands_auipc_o(inst1_operands_auipc_o),
        .inst0_operands_sid_o(inst0_operands_sid_o), .inst1_operands_sid_o(inst1_operands_sid_o),
        .stall_cnt_o(stall_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid_i = 0; flush_i = 0;
        inst0_issue_valid_i = 0; inst1_issue_valid_i = 0;
        inst0_issue_pc_i = '0; inst1_issue_pc_i = '0; inst0_issue_inst_i = '0; inst1_issue_inst_i = '0;
        {inst0_issue_rs1_valid_i, inst0_issue_rs2_valid_i, inst0_issue_rs3_valid_i} = '0;
        {inst1_issue_rs1_valid_i, inst1_issue_rs2_valid_i, inst1_issue_rs3_valid_i} = '0;
        {inst0_issue_rs1_idx_i, inst0_issue_rs2_idx_i, inst0_issue_rs3_idx_i} = '0;
        {inst1_issue_rs1_idx_i, inst1_issue_rs2_idx_i, inst1_issue_rs3_idx_i} = '0;
        {inst0_issue_rs1_value_i, inst0_issue_rs2_value_i, inst0_issue_rs3_value_i} = '0;
        {inst1_issue_rs1_value_i, inst1_issue_rs2_value_i, inst1_issue_rs3_value_i} = '0;
        inst0_issue_rd_type_i = 0; inst1_issue_rd_type_i = 0; inst0_issue_rd_i = 0; inst1_issue_rd_i = 0;
        inst0_issue_h_exe_unit_i = 0; inst1_issue_h_exe_unit_i = 0;
        inst0_issue_func_code_i = 0; inst1_issue_func_code_i = 0;
        inst0_issue_func3_i = 0; inst1_issue_func3_i = 0; inst0_issue_func2_i = 0; inst1_issue_func2_i = 0;
        inst0_issue_endsim_i = 0; inst1_issue_endsim_i = 0; inst0_issue_auipc_i = 0; inst1_issue_auipc_i = 0;
        inst0_issue_sid_i = 0; inst1_issue_sid_i = 0;
        wb0_valid_i = 0; wb1_valid_i = 0; wb0_rd_type_i = 0; wb1_rd_type_i = 0;
        wb0_rd_i = 0; wb1_rd_i = 0; wb0_value_i = '0; wb1_value_i = '0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0; exe_ready_i = 1;
        #11;
        chk("reset_v0", inst0_operands_valid_o, 0);
        chk("reset_v1", inst1_operands_valid_o, 0);
        chk("reset_pc0", inst0_operands_pc_o, 0);
        chk("reset_stall", stall_cnt_o, 0);
        chk("reset_ready", issue_ready_o, 1);
        #1 rst_n = 1;
        tick();

        // First pair
        issue_valid_i = 1;
        inst0_issue_valid_i = 1; inst0_issue_pc_i = 64'h1000; inst0_issue_inst_i = 32'h00000013;
        inst0_issue_rs1_valid_i = 1; inst0_issue_rs1_idx_i = 1; inst0_issue_rs1_value_i = 64'h11;
        inst0_issue_rs2_valid_i = 1; inst0_issue_rs2_idx_i = 7; inst0_issue_rs2_value_i = 64'h77;
        inst0_issue_rd_type_i = 2'b01; inst0_issue_rd_i = 3; inst0_issue_h_exe_unit_i = 4'b0001;
        inst0_issue_func_code_i = 4'h2; inst0_issue_func3_i = 3; inst0_issue_func2_i = 1; inst0_issue_sid_i = 5;
        inst1_issue_valid_i = 1; inst1_issue_pc_i = 64'h1004; inst1_issue_inst_i = 32'h00100093;
        inst1_issue_rs1_valid_i = 1; inst1_issue_rs1_idx_i = 5; inst1_issue_rs1_value_i = 64'h55;
        inst1_issue_rd_type_i = 2'b01; inst1_issue_rd_i = 4; inst1_issue_sid_i = 6; inst1_issue_auipc_i = 1;
        #1 chk("load_ready", issue_ready_o, 1);
        tick();
        issue_valid_i = 0; exe_ready_i = 0;
        chk("load_v0", inst0_operands_valid_o, 1);
        chk("load_v1", inst1_operands_valid_o, 1);
        chk("load_pc0", inst0_operands_pc_o, 64'h1000);
        chk("load_pc1", inst1_operands_pc_o, 64'h1004);
        chk("load_inst0", inst0_operands_inst_o, 32'h00000013);
        chk("load_rs2v0", inst0_operands_rs2_value_o, 64'h77);
        chk("load_func3_0", inst0_operands_func3_o, 3);
        chk("load_sid1", inst1_operands_sid_o, 6);
        chk("load_auipc1", inst1_operands_auipc_o, 1);
        #1 chk("hold_ready", issue_ready_o, 0);

        // Hold three cycles; writeback forward during the last one
        tick(); tick();
        wb0_valid_i = 1; wb0_rd_type_i = 2'b01; wb0_rd_i = 7; wb0_value_i = 64'hAA;
        wb1_valid_i = 1; wb1_rd_type_i = 2'b01; wb1_rd_i = 7; wb1_value_i = 64'hBB;
        tick();
        wb0_valid_i = 0; wb1_valid_i = 0;
        chk("hold_stall3", stall_cnt_o, 3);
        chk("hold_pc0", inst0_operands_pc_o, 64'h1000);
        chk("hold_v1", inst1_operands_valid_o, 1);
        chk("hold_fwd_wb1_wins", inst0_operands_rs2_value_o, 64'hBB);
        chk("hold_nofwd_rs1", inst0_operands_rs1_value_o, 64'h11);
        chk("hold_nofwd_l1", inst1_operands_rs1_value_o, 64'h55);
        exe_ready_i = 1;
        tick();
        chk("drain_v0", inst0_operands_valid_o, 0);
        chk("drain_v1", inst1_operands_valid_o, 0);
        chk("drain_stall", stall_cnt_o, 3);
        chk("drain_ready", issue_ready_o, 1);

        // Load forwarding: x0 never forwarded, rs3 picks up wb1
        clear_inputs();
        issue_valid_i = 1;
        inst0_issue_valid_i = 1; inst0_issue_pc_i = 64'h2000;
        inst0_issue_rs3_valid_i = 1; inst0_issue_rs3_idx_i = 9; inst0_issue_rs3_value_i = 64'h90;
        inst1_issue_valid_i = 1; inst1_issue_pc_i = 64'h2004;
        inst1_issue_rs1_valid_i = 1; inst1_issue_rs1_idx_i = 0; inst1_issue_rs1_value_i = 64'h99;
        wb0_valid_i = 1; wb0_rd_type_i = 2'b01; wb0_rd_i = 0; wb0_value_i = 64'hDEAD;
        wb1_valid_i = 1; wb1_rd_type_i = 2'b01; wb1_rd_i = 9; wb1_value_i = 64'h1234;
        tick();
        chk("ld_x0_nofwd", inst1_operands_rs1_value_o, 64'h99);
        chk("ld_rs3_fwd", inst0_operands_rs3_value_o, 64'h1234);
        // Back-to-back: drain and load in one edge; FP writeback must not forward
        wb1_valid_i = 0;
        inst1_issue_pc_i = 64'h3004; inst1_issue_rs1_idx_i = 5; inst1_issue_rs1_value_i = 64'h55;
        wb0_rd_type_i = 2'b10; wb0_rd_i = 5;
        #1 chk("b2b_ready", issue_ready_o, 1);
        tick();
        chk("b2b_pc1", inst1_operands_pc_o, 64'h3004);
        chk("b2b_v1", inst1_operands_valid_o, 1);
        chk("ld_fp_nofwd", inst1_operands_rs1_value_o, 64'h55);

        // Flush overrides a held pair and a pending issue
        clear_inputs();
        issue_valid_i = 1; inst0_issue_valid_i = 1; inst1_issue_valid_i = 1; inst0_issue_pc_i = 64'h4000;
        tick();
        issue_valid_i = 0; exe_ready_i = 0;
        tick();
        chk("pre_flush_stall", stall_cnt_o, 4);
        flush_i = 1; issue_valid_i = 1;
        #1 chk("flush_ready", issue_ready_o, 0);
        tick();
        chk("flush_v0", inst0_operands_valid_o, 0);
        chk("flush_v1", inst1_operands_valid_o, 0);
        chk("flush_stall", stall_cnt_o, 4);
        flush_i = 0; issue_valid_i = 0; exe_ready_i = 1;

        // Partial pair: lane1 invalid gets no forward
        clear_inputs();
        issue_valid_i = 1; inst0_issue_valid_i = 1; inst0_issue_pc_i = 64'h5000;
        inst1_issue_rs1_valid_i = 1; inst1_issue_rs1_idx_i = 6; inst1_issue_rs1_value_i = 64'h66;
        wb0_valid_i = 1; wb0_rd_type_i = 2'b01; wb0_rd_i = 6; wb0_value_i = 64'hFF;
        tick();
        chk("part_v0", inst0_operands_valid_o, 1);
        chk("part_v1", inst1_operands_valid_o, 0);
        chk("part_nofwd_l1", inst1_operands_rs1_value_o, 64'h66);
        clear_inputs(); exe_ready_i = 0;
        tick();
        chk("part_stall", stall_cnt_o, 5);

        // Async reset between edges
        #3 rst_n = 0;
        #1;
        chk("arst_v0", inst0_operands_valid_o, 0);
        chk("arst_pc0", inst0_operands_pc_o, 0);
        chk("arst_rs1v1", inst1_operands_rs1_value_o, 0);
        chk("arst_stall", stall_cnt_o, 0);
        chk("arst_ready", issue_ready_o, 1);
        #3 rst_n = 1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/exe_operands_pipe.md
Name: exe_operands_pipe

Overview:
- Two-lane pipeline register between regfile-read/issue and the execute sequencer; its outputs are the inst0/inst1 operand bundles the sequencer routes to ALU0/ALU1/BEU/LSU.
- Valid/ready handshake per instruction pair, flush, and writeback forwarding into captured and held operand values.
- Saturating stall-cycle counter for performance monitoring.

Parameters:
- XLEN, 64, operand value width.
- SID_W, `SCOREBOARD_SIZE_WIDTH+1, scoreboard id width.
- HU_W, `H_EXE_UNIT_WIDTH, one-hot execute-unit select width.
- RD_INT, 2'b01, rd_type/rs encoding meaning integer register file.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush (branch redirect/exception)
- issue_valid_i  in  1  upstream pair valid
- issue_ready_o  out  1  pair accepted this cycle when valid&ready
- inst{0,1}_issue_valid_i  in  1  lane valid within pair
- inst{0,1}_issue_{pc,inst}_i  in  64/32  lane pc and instruction word
- inst{0,1}_issue_rs{1,2,3}_{valid,idx,value}_i  in  1/5/XLEN  source operands as read from regfile
- inst{0,1}_issue_{rd_type,rd,h_exe_unit,func_code,func3,func2,endsim,auipc,sid}_i  in  2/5/HU_W/4/3/2/1/1/SID_W  decode fields
- wb{0,1}_valid_i  in  1  writeback port valid; wb1 is younger
- wb{0,1}_{rd_type,rd,value}_i  in  2/5/XLEN  writeback destination and data
- exe_ready_i  in  1  sequencer/execute units accept held pair
- inst{0,1}_operands_*_o  out  same widths as issue fields  registered operand bundle (valid, pc, inst, rs1-3 valid/idx/value, rd_type, rd, h_exe_unit, func_code, func3, func2, endsim, auipc, sid)
- stall_cnt_o  out  CNT_W  cycles held pair was valid and exe_ready_i low

Behaviour:
- Reset: all inst{0,1}_operands_*_o zero (valid 0); stall_cnt_o 0; issue_ready_o reads 1 after reset.
- Occupancy: occ = inst0_operands_valid_o | inst1_operands_valid_o.
- issue_ready_o = !flush_i & (!occ | exe_ready_i); combinational.
- Load: issue_valid_i & issue_ready_o -> next cycle lanes capture issue fields; lane valid = inst{n}_issue_valid_i. Latency 1 cycle.
- Drain without load: occ & exe_ready_i & !load -> lane valids clear next cycle.
- Hold: occ & !exe_ready_i -> all fields hold except forwarded values.
- Flush: flush_i clears both lane valids next cycle and overrides load, hold and forwarding; data fields may keep stale values.
- Forward match: wbK_valid_i & wbK_rd_type_i==RD_INT & wbK_rd_i!=0 & rsJ_valid & rsJ_idx==wbK_rd_i.
  - Applied to incoming values on load and to held values on hold, independently per lane and per rs1/rs2/rs3.
  - Both ports match: wb1 value wins.
  - No forwarding into a lane whose valid is 0.
  - rsJ_idx 0 is never forwarded; it stays at the regfile value.
- Simultaneous drain+load is allowed: new pair replaces old in the same edge.
- stall_cnt_o increments when occ & !exe_ready_i & !flush_i; saturates at all-ones; never clears except reset.
- Reset asserted mid-hold: outputs zero immediately (asynchronous); the pending pair is lost.

Decomposition:
- Shared package/header: H_* unit indices, H_EXE_UNIT_WIDTH, SCOREBOARD_SIZE_WIDTH, rd_type encodings (RD_INT etc.).
- One sub-module, exe_fwd_mux: given rs valid/idx/value plus both wb ports, returns the forwarded value.
  - Instantiated 6 times on the load path and 6 on the hold path, or shared via a select.

Test Plan:
- Reset release, issue pair (pc0=0x1000, pc1=0x1004, both valid, exe_ready_i=1) -> both valids 1 after one clk with fields equal to inputs; issue_ready_o=1 throughout.
- Hold: exe_ready_i=0 for 3 cycles with pair held -> outputs stable, issue_ready_o=0, stall_cnt_o=3; exe_ready_i=1 -> pair drains and stall_cnt_o stays 3.
- Forward while held: inst0 rs2_idx=7 held, wb0 rd=7 value 0xAA, wb1 rd=7 value 0xBB same cycle -> inst0_operands_rs2_value_o=0xBB next cycle.
- Forward on load: inst1 rs1_idx=0 and wb0 rd=0 -> no change. Separately, rs1_idx=5 with wb0 rd_type=FP rd=5 -> no forward.
- Flush: flush_i with issue_valid_i=1 and pair held -> issue_ready_o=0, both valids 0 next cycle, stall_cnt_o not incremented that cycle.
- Partial pair and async reset: inst1_issue_valid_i=0 -> inst1_operands_valid_o=0, no forward into lane1. Assert rst_n=0 mid-hold between edges -> all outputs 0 immediately.
